// File: rtl/op_sequencer_if.sv
// Bus between the push-button/switch front end and the instruction sequencer.
// The front end (master) drives keys and switches; the sequencer (slave) drives datapath controls.
interface op_sequencer_if #(
   parameter int ADDR_W  = 4,
   parameter int OPCNT_W = 8
);
   logic               key_exec_lvl;
   logic               key_show_lvl;
   logic [3:0]         sw_codop;
   logic [ADDR_W-1:0]  sw_dst;
   logic [ADDR_W-1:0]  sw_src_a;
   logic [ADDR_W-1:0]  sw_src_b;

   logic [ADDR_W-1:0]  addr_a;
   logic [ADDR_W-1:0]  addr_b;
   logic [ADDR_W-1:0]  write_reg;
   logic               sel_imm;
   logic               alu_en;
   logic               reg_we;
   logic               show_valid;
   logic               busy;
   logic [OPCNT_W-1:0] op_count;
   logic [2:0]         state;

   modport master (
      output key_exec_lvl, key_show_lvl, sw_codop, sw_dst, sw_src_a, sw_src_b,
      input  addr_a, addr_b, write_reg, sel_imm, alu_en, reg_we,
             show_valid, busy, op_count, state
   );

   modport slave (
      input  key_exec_lvl, key_show_lvl, sw_codop, sw_dst, sw_src_a, sw_src_b,
      output addr_a, addr_b, write_reg, sel_imm, alu_en, reg_we,
             show_valid, busy, op_count, state
   );
endinterface

// File: rtl/op_sequencer.sv
// Turns debounced execute/show key levels into single-cycle strobes and sequences
// each instruction through latch, decode, ALU execute and register write-back.
module op_sequencer #(
   parameter int ADDR_W  = 4,
   parameter int OPCNT_W = 8
) (
   input logic           clk,
   input logic           rst,
   op_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      DECODE  = 3'd1,
      EXEC    = 3'd2,
      WRITE   = 3'd3,
      RELEASE = 3'd4,
      SHOW    = 3'd5
   } state_e;

   state_e             state_q;
   state_e             state_d;
   logic               execPrev_q;
   logic               showPrev_q;
   logic               riseExec;
   logic               riseShow;
   logic [3:0]         opCodop_q;
   logic [ADDR_W-1:0]  opDst_q;
   logic [ADDR_W-1:0]  opSrcA_q;
   logic [ADDR_W-1:0]  opSrcB_q;
   logic               aluEn_q;
   logic               regWe_q;
   logic               showValid_q;
   logic               busy_q;
   logic [OPCNT_W-1:0] opCount_q;
   logic               liveSel;
   logic [3:0]         selCode;

   // Prev registers reset to 1 so a key held through reset never looks like a fresh press.
   always_comb begin
      riseExec = bus.key_exec_lvl & ~execPrev_q;
      riseShow = bus.key_show_lvl & ~showPrev_q;
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE: begin
            if (riseExec) begin
               state_d = DECODE;
            end else if (riseShow) begin
               state_d = SHOW;
            end else begin
               state_d = IDLE;
            end
         end
         DECODE:  state_d = EXEC;
         EXEC:    state_d = WRITE;
         WRITE:   state_d = RELEASE;
         RELEASE: state_d = bus.key_exec_lvl ? RELEASE : IDLE;
         SHOW:    state_d = bus.key_show_lvl ? SHOW : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up exactly with their state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         execPrev_q  <= 1'b1;
         showPrev_q  <= 1'b1;
         opCodop_q   <= '0;
         opDst_q     <= '0;
         opSrcA_q    <= '0;
         opSrcB_q    <= '0;
         aluEn_q     <= 1'b0;
         regWe_q     <= 1'b0;
         showValid_q <= 1'b0;
         busy_q      <= 1'b0;
         opCount_q   <= '0;
      end else begin
         state_q     <= state_d;
         execPrev_q  <= bus.key_exec_lvl;
         showPrev_q  <= bus.key_show_lvl;
         if (state_q == IDLE && riseExec) begin
            opCodop_q <= bus.sw_codop;
            opDst_q   <= bus.sw_dst;
            opSrcA_q  <= bus.sw_src_a;
            opSrcB_q  <= bus.sw_src_b;
         end
         aluEn_q     <= (state_d == EXEC);
         regWe_q     <= (state_d == WRITE);
         showValid_q <= (state_d == SHOW);
         busy_q      <= (state_d == DECODE) || (state_d == EXEC) || (state_d == WRITE);
         if (state_d == WRITE) begin
            opCount_q <= opCount_q + OPCNT_W'(1);
         end
      end
   end

   // Idle and show modes display the live switch selection; otherwise the latched instruction drives the bank.
   always_comb begin
      liveSel     = (state_q == IDLE) || (state_q == SHOW);
      selCode     = liveSel ? bus.sw_codop : opCodop_q;
      bus.addr_a  = liveSel ? bus.sw_dst   : opSrcA_q;
      bus.addr_b  = liveSel ? bus.sw_src_b : opSrcB_q;
      bus.sel_imm = selCode[3] | (selCode[1] & (~selCode[0] | selCode[2]));
   end

   assign bus.write_reg  = opDst_q;
   assign bus.alu_en     = aluEn_q;
   assign bus.reg_we     = regWe_q;
   assign bus.show_valid = showValid_q;
   assign bus.busy       = busy_q;
   assign bus.op_count   = opCount_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_op_sequencer.sv
// Directed bench for op_sequencer: a per-cycle reference model tracks instruction age
// and show mode, plus literal expectations at the interesting points of each scenario.
module tb_op_sequencer;

   localparam int ADDR_W  = 4;
   localparam int OPCNT_W = 8;

   logic clk;
   logic rst;

   op_sequencer_if #(.ADDR_W(ADDR_W), .OPCNT_W(OPCNT_W)) bus ();

   op_sequencer #(.ADDR_W(ADDR_W), .OPCNT_W(OPCNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: age 0 = no instruction, 1..3 = decode/exec/write, 4 = waiting for key release.
   int         mAge;
   bit         mShow;
   int         mCount;
   logic [3:0] mCodop;
   logic [3:0] mDst;
   logic [3:0] mSrcA;
   logic [3:0] mSrcB;
   logic       mPrevE;
   logic       mPrevS;
   logic       riseE;
   logic       riseS;
   bit         modelValid = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic expSel(input logic [3:0] c);
      logic [15:0] immMask;
      immMask = 16'hFFC4;
      return immMask[c];
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic r, input logic e, input logic s,
                                input logic [3:0] c, input logic [3:0] d,
                                input logic [3:0] a, input logic [3:0] b);
      @(posedge clk);
      #1;
      rst              = r;
      bus.key_exec_lvl = e;
      bus.key_show_lvl = s;
      bus.sw_codop     = c;
      bus.sw_dst       = d;
      bus.sw_src_a     = a;
      bus.sw_src_b     = b;
   endtask

   task automatic settle();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      forever begin
         @(posedge clk);
         if (rst) begin
            mAge   = 0;
            mShow  = 1'b0;
            mCount = 0;
            mCodop = '0;
            mDst   = '0;
            mSrcA  = '0;
            mSrcB  = '0;
            mPrevE = 1'b1;
            mPrevS = 1'b1;
            modelValid = 1'b1;
         end else begin
            riseE = bus.key_exec_lvl & ~mPrevE;
            riseS = bus.key_show_lvl & ~mPrevS;
            if (mAge == 4) begin
               if (!bus.key_exec_lvl) mAge = 0;
            end else if (mAge > 0) begin
               mAge++;
               if (mAge == 3) mCount = (mCount + 1) % (1 << OPCNT_W);
            end else if (mShow) begin
               if (!bus.key_show_lvl) mShow = 1'b0;
            end else if (riseE) begin
               mCodop = bus.sw_codop;
               mDst   = bus.sw_dst;
               mSrcA  = bus.sw_src_a;
               mSrcB  = bus.sw_src_b;
               mAge   = 1;
            end else if (riseS) begin
               mShow = 1'b1;
            end
            mPrevE = bus.key_exec_lvl;
            mPrevS = bus.key_show_lvl;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (modelValid) begin
            checkOutput("model_state",      bus.state,      mShow ? 32'd5 : 32'(mAge));
            checkOutput("model_addr_a",     bus.addr_a,     (mAge == 0) ? bus.sw_dst   : mSrcA);
            checkOutput("model_addr_b",     bus.addr_b,     (mAge == 0) ? bus.sw_src_b : mSrcB);
            checkOutput("model_sel_imm",    bus.sel_imm,    expSel((mAge == 0) ? bus.sw_codop : mCodop));
            checkOutput("model_write_reg",  bus.write_reg,  mDst);
            checkOutput("model_alu_en",     bus.alu_en,     mAge == 2);
            checkOutput("model_reg_we",     bus.reg_we,     mAge == 3);
            checkOutput("model_busy",       bus.busy,       (mAge >= 1) && (mAge <= 3));
            checkOutput("model_show_valid", bus.show_valid, mShow);
            checkOutput("model_op_count",   bus.op_count,   mCount);
         end
      end
   end

   initial begin
      logic [3:0] v;
      rst              = 1'b1;
      bus.key_exec_lvl = 1'b0;
      bus.key_show_lvl = 1'b0;
      bus.sw_codop     = '0;
      bus.sw_dst       = '0;
      bus.sw_src_a     = '0;
      bus.sw_src_b     = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_state",     bus.state,     0);
      checkOutput("reset_op_count",  bus.op_count,  0);
      checkOutput("reset_write_reg", bus.write_reg, 0);
      checkOutput("reset_busy",      bus.busy,      0);

      $display("[TB] basic instruction");
      applyStimulus(0, 0, 0, 4'h0, 4'd4, 4'd2, 4'd3);
      applyStimulus(0, 1, 0, 4'h0, 4'd4, 4'd2, 4'd3);
      settle();
      checkOutput("t1_decode_state",  bus.state,   1);
      checkOutput("t1_decode_addr_a", bus.addr_a,  2);
      checkOutput("t1_decode_addr_b", bus.addr_b,  3);
      checkOutput("t1_decode_sel",    bus.sel_imm, 0);
      settle();
      checkOutput("t1_exec_alu_en",   bus.alu_en,  1);
      checkOutput("t1_exec_reg_we",   bus.reg_we,  0);
      settle();
      checkOutput("t1_write_reg_we",  bus.reg_we,    1);
      checkOutput("t1_write_alu_en",  bus.alu_en,    0);
      checkOutput("t1_write_reg",     bus.write_reg, 4);
      checkOutput("t1_op_count",      bus.op_count,  1);
      repeat (3) applyStimulus(0, 0, 0, 4'h0, 4'd4, 4'd2, 4'd3);

      $display("[TB] immediate opcode with long key hold");
      applyStimulus(0, 1, 0, 4'hA, 4'd5, 4'd1, 4'd2);
      repeat (100) applyStimulus(0, 1, 0, 4'h0, 4'd5, 4'd1, 4'd2);
      @(negedge clk);
      checkOutput("t2_release_state", bus.state,   4);
      checkOutput("t2_release_sel",   bus.sel_imm, 1);
      checkOutput("t2_release_we",    bus.reg_we,  0);
      applyStimulus(0, 0, 0, 4'h0, 4'd5, 4'd1, 4'd2);
      settle();
      checkOutput("t2_idle_state",    bus.state,    0);
      checkOutput("t2_idle_sel",      bus.sel_imm,  0);
      checkOutput("t2_op_count",      bus.op_count, 2);

      $display("[TB] switch change during execute");
      applyStimulus(0, 1, 0, 4'h0, 4'd6, 4'd2, 4'd1);
      settle();
      applyStimulus(0, 1, 0, 4'h0, 4'd6, 4'd7, 4'd1);
      @(negedge clk);
      checkOutput("t3_exec_state",    bus.state,  2);
      checkOutput("t3_exec_addr_a",   bus.addr_a, 2);
      settle();
      checkOutput("t3_write_addr_a",  bus.addr_a,    2);
      checkOutput("t3_write_reg",     bus.write_reg, 6);
      repeat (3) applyStimulus(0, 0, 0, 4'h0, 4'd6, 4'd7, 4'd1);

      $display("[TB] exec and show together, exec inside show");
      applyStimulus(0, 1, 1, 4'h3, 4'd8, 4'd4, 4'd5);
      settle();
      checkOutput("t4_both_state",    bus.state,      1);
      checkOutput("t4_both_show",     bus.show_valid, 0);
      repeat (3) applyStimulus(0, 1, 1, 4'h3, 4'd8, 4'd4, 4'd5);
      repeat (3) applyStimulus(0, 0, 0, 4'h3, 4'd8, 4'd4, 4'd5);
      applyStimulus(0, 0, 1, 4'h6, 4'd9, 4'd4, 4'd5);
      settle();
      checkOutput("t4_show_state",    bus.state,      5);
      checkOutput("t4_show_valid",    bus.show_valid, 1);
      checkOutput("t4_show_addr_a",   bus.addr_a,     9);
      applyStimulus(0, 1, 1, 4'h6, 4'd9, 4'd4, 4'd5);
      settle();
      checkOutput("t4_exec_in_show",  bus.state, 5);
      checkOutput("t4_exec_in_busy",  bus.busy,  0);
      applyStimulus(0, 1, 0, 4'h6, 4'd9, 4'd4, 4'd5);
      settle();
      checkOutput("t4_show_exit",     bus.state, 0);
      repeat (3) applyStimulus(0, 1, 0, 4'h6, 4'd9, 4'd4, 4'd5);
      @(negedge clk);
      checkOutput("t4_held_no_instr", bus.state,    0);
      checkOutput("t4_op_count",      bus.op_count, 4);
      repeat (2) applyStimulus(0, 0, 0, 4'h0, 4'd9, 4'd4, 4'd5);

      $display("[TB] reset during execute");
      applyStimulus(0, 1, 0, 4'h1, 4'd9, 4'd1, 4'd2);
      settle();
      applyStimulus(1, 1, 0, 4'h1, 4'd9, 4'd1, 4'd2);
      @(negedge clk);
      checkOutput("t5_exec_alu_en",   bus.alu_en, 1);
      settle();
      checkOutput("t5_rst_state",     bus.state,     0);
      checkOutput("t5_rst_reg_we",    bus.reg_we,    0);
      checkOutput("t5_rst_op_count",  bus.op_count,  0);
      checkOutput("t5_rst_write_reg", bus.write_reg, 0);
      repeat (5) applyStimulus(0, 1, 0, 4'h1, 4'd9, 4'd1, 4'd2);
      @(negedge clk);
      checkOutput("t5_held_state",    bus.state,    0);
      checkOutput("t5_held_count",    bus.op_count, 0);
      repeat (2) applyStimulus(0, 0, 0, 4'h0, 4'd0, 4'd0, 4'd0);

      $display("[TB] counter wrap");
      for (int i = 0; i < 256; i++) begin
         v = 4'(i);
         repeat (4) applyStimulus(0, 1, 0, v, v, ~v, v ^ 4'h5);
         repeat (2) applyStimulus(0, 0, 0, v, v, ~v, v ^ 4'h5);
         if (i == 254) begin
            @(negedge clk);
            checkOutput("t6_count_ff", bus.op_count, 8'hFF);
         end
      end
      @(negedge clk);
      checkOutput("t6_count_wrap", bus.op_count, 8'h00);
      repeat (2) applyStimulus(0, 0, 0, 4'h0, 4'd0, 4'd0, 4'd0);
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/op_sequencer.md
Name: op_sequencer

Overview:
Control FSM between the debounced push-button levels and the register bank/ALU datapath of the HAL board top level. It turns KEY3 (execute) and KEY0 (show) level signals into single-cycle, clk-synchronous strobes. It sequences each instruction as latch → decode → ALU execute → register write-back, and drives the operand-address and immediate-select muxes. It replaces the ad-hoc key-derived clocks with one clock domain.

Parameters:
ADDR_W, 4, register address width
OPCNT_W, 8, width of the retired-instruction counter

Ports:
clk  in  1  system clock (50 MHz board clock)
rst  in  1  synchronous reset, active-high
key_exec_lvl  in  1  debounced execute key level, 1 = pressed
key_show_lvl  in  1  debounced show key level, 1 = pressed
sw_codop  in  4  opcode switches
sw_dst  in  ADDR_W  destination / display-A register switches
sw_src_a  in  ADDR_W  source-A register switches
sw_src_b  in  ADDR_W  source-B register or immediate switches
addr_a  out  ADDR_W  register bank read address A
addr_b  out  ADDR_W  register bank read address B
write_reg  out  ADDR_W  register bank write address
sel_imm  out  1  1 = ALU operand B is the zero-extended immediate from addr_b
alu_en  out  1  one-cycle ALU execute strobe
reg_we  out  1  one-cycle register write strobe
show_valid  out  1  display-registers mode active
busy  out  1  instruction in flight
op_count  out  OPCNT_W  retired-instruction count
state  out  3  current FSM state, for debug

Behaviour:
- Edge detect: exec_prev and show_prev are registered each cycle. rise_x = lvl_x & ~prev_x.
- On rst, both prev registers load 1. A key held through reset therefore never produces a rise.
- Instruction latch: op_codop, op_dst, op_src_a and op_src_b load from the switches only on an accepted exec rise. Switch changes after that point do not affect the instruction in flight.
- States: IDLE=0, DECODE=1, EXEC=2, WRITE=3, RELEASE=4, SHOW=5. Codes 6 and 7 return to IDLE on the next cycle.
- IDLE:
  - addr_a = sw_dst and addr_b = sw_src_b, combinationally from the live switches.
  - On rise_exec: latch the instruction, go to DECODE.
  - Else on rise_show: go to SHOW.
  - If both rise in the same cycle, exec wins and the show rise is discarded.
- DECODE, 1 cycle: addr_a = op_src_a, addr_b = op_src_b. Go to EXEC.
- EXEC, 1 cycle: alu_en = 1, addresses as in DECODE. Go to WRITE.
- WRITE, 1 cycle:
  - reg_we = 1, write_reg = op_dst, addresses held.
  - op_count increments, wrapping from all-ones to 0.
  - Go to RELEASE.
- RELEASE: hold until key_exec_lvl == 0, then go to IDLE. Further exec or show rises while in RELEASE are ignored.
- SHOW:
  - show_valid = 1, addr_a = sw_dst, addr_b = sw_src_b (live switches).
  - Stays while key_show_lvl == 1. Goes to IDLE in the first cycle the level is 0.
  - Minimum dwell is 1 cycle.
  - A rise_exec while in SHOW is ignored.
- sel_imm:
  - sel_imm = c[3] | (c[1] & (~c[0] | c[2])).
  - c = op_codop in DECODE, EXEC, WRITE and RELEASE.
  - c = sw_codop in IDLE and SHOW.
- busy = 1 in DECODE, EXEC and WRITE, else 0. write_reg = op_dst at all times.
- Latency: rise_exec sampled at edge N gives DECODE in cycle N+1, alu_en high in N+2, reg_we high in N+3. This is exactly one instruction per key press.
- Reset values:
  - state = IDLE.
  - alu_en, reg_we, show_valid and busy = 0.
  - op_count = 0.
  - op_* registers = 0, so write_reg = 0.
- Reset mid-operation: rst has priority in every state. No alu_en or reg_we is issued in the cycle after rst, and the instruction is dropped.
- alu_en and reg_we are never high in the same cycle and are never high outside EXEC and WRITE respectively.

Test Plan:
- Reset, then pulse key_exec_lvl with codop=0x0, dst=4, src_a=2, src_b=3 → DECODE, EXEC, WRITE on consecutive cycles, each strobe exactly 1 cycle wide. In DECODE, addr_a=2, addr_b=3, sel_imm=0. In WRITE, write_reg=4. op_count=1.
- codop=0xA with exec held 100 cycles → sel_imm=1 from DECODE through RELEASE. A single reg_we pulse. state=RELEASE until the level drops, then IDLE.
- Change sw_src_a 2→7 during EXEC → addr_a stays 2 through WRITE.
- key_exec_lvl and key_show_lvl rise in the same cycle → DECODE entered, show_valid stays 0. While in SHOW, a rise_exec does not start an instruction.
- Assert rst during EXEC → reg_we never pulses. op_count=0, state=0 after one cycle. A key held through reset produces no instruction after release of rst.
- 256 exec presses with OPCNT_W=8 → op_count wraps from 0xFF to 0x00.
